// File: rtl/tmon_responder.sv
// tmon_bus responder: executes threshold/read/clear commands through an
// IDLE -> EXEC -> RESP sequence and tracks over/under-temperature alarms
// from the sensor sample stream.

package tmon_pkg;
    typedef enum logic [2:0] {
        TMON_NOP     = 3'd0,
        TMON_SET_HI  = 3'd1,
        TMON_SET_LO  = 3'd2,
        TMON_RD_TEMP = 3'd3,
        TMON_RD_HI   = 3'd4,
        TMON_RD_LO   = 3'd5,
        TMON_CLR     = 3'd6
    } tmon_op_t;

    typedef enum logic [1:0] {
        TMON_OK    = 2'd0,
        TMON_ERR   = 2'd1,
        TMON_ALARM = 2'd2
    } tmon_status_t;
endpackage

module tmon_responder
    import tmon_pkg::*;
#(
    parameter int unsigned    DW     = 8,
    parameter int unsigned    HYST   = 2,
    parameter logic [DW-1:0]  HI_RST = 8'd200,
    parameter logic [DW-1:0]  LO_RST = 8'd10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  tmon_op_t            op,
    input  logic [DW-1:0]       opnd,
    output tmon_status_t        status,
    output logic                valid,
    output logic                ready,
    output logic [DW-1:0]       rdata,
    input  logic [DW-1:0]       temp_in,
    input  logic                temp_vld,
    output logic                alarm_hi,
    output logic                alarm_lo,
    output logic                alarm_sticky
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [DW-1:0] LP_HYST = DW'(HYST);
    localparam logic [DW-1:0] LP_MAX  = '1;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_exec;
    logic           w_ready;
    logic           w_valid;

    tmon_op_t       r_op;
    logic [DW-1:0]  r_opnd;
    logic [DW-1:0]  r_hi_thr;
    logic [DW-1:0]  r_lo_thr;
    logic [DW-1:0]  r_last_temp;
    tmon_status_t   r_status;
    logic [DW-1:0]  r_rdata;
    logic           r_alarm_hi;
    logic           r_alarm_lo;
    logic           r_sticky;

    logic [DW-1:0]  w_hi_nxt;
    logic [DW-1:0]  w_lo_nxt;
    tmon_status_t   w_status_nxt;
    logic [DW-1:0]  w_rdata_nxt;
    logic           w_clr;
    logic [DW-1:0]  w_hi_clr_thr;
    logic [DW-1:0]  w_lo_clr_thr;
    logic           w_alarm_hi_nxt;
    logic           w_alarm_lo_nxt;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (op != TMON_NOP) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the command on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= TMON_NOP;
            r_opnd <= '0;
        end else if (w_accept) begin
            r_op   <= op;
            r_opnd <= opnd;
        end
    end

    // Command execution: threshold updates and response formation
    always_comb begin
        w_hi_nxt     = r_hi_thr;
        w_lo_nxt     = r_lo_thr;
        w_status_nxt = TMON_OK;
        w_rdata_nxt  = '0;
        w_clr        = 1'b0;
        case (r_op)
            TMON_SET_HI: begin
                if (r_opnd <= r_lo_thr) w_status_nxt = TMON_ERR;
                else                    w_hi_nxt     = r_opnd;
            end
            TMON_SET_LO: begin
                if (r_opnd >= r_hi_thr) w_status_nxt = TMON_ERR;
                else                    w_lo_nxt     = r_opnd;
            end
            TMON_RD_TEMP: begin
                w_rdata_nxt  = r_last_temp;
                w_status_nxt = (r_alarm_hi || r_alarm_lo) ? TMON_ALARM : TMON_OK;
            end
            TMON_RD_HI: begin
                w_rdata_nxt  = r_hi_thr;
                w_status_nxt = (r_alarm_hi || r_alarm_lo) ? TMON_ALARM : TMON_OK;
            end
            TMON_RD_LO: begin
                w_rdata_nxt  = r_lo_thr;
                w_status_nxt = (r_alarm_hi || r_alarm_lo) ? TMON_ALARM : TMON_OK;
            end
            TMON_CLR: w_clr = 1'b1;
            default:  w_status_nxt = TMON_ERR;
        endcase
    end

    // Threshold and response registers, written only during EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_thr <= HI_RST;
            r_lo_thr <= LO_RST;
            r_status <= TMON_OK;
            r_rdata  <= '0;
        end else if (w_exec) begin
            r_hi_thr <= w_hi_nxt;
            r_lo_thr <= w_lo_nxt;
            r_status <= w_status_nxt;
            r_rdata  <= w_rdata_nxt;
        end
    end

    // Hysteresis clear points, saturating instead of wrapping
    always_comb begin
        w_hi_clr_thr = (r_hi_thr >= LP_HYST) ? (r_hi_thr - LP_HYST) : '0;
        w_lo_clr_thr = (r_lo_thr > (LP_MAX - LP_HYST)) ? LP_MAX : (r_lo_thr + LP_HYST);
        w_alarm_hi_nxt = r_alarm_hi;
        w_alarm_lo_nxt = r_alarm_lo;
        if (temp_in > r_hi_thr)          w_alarm_hi_nxt = 1'b1;
        else if (temp_in < w_hi_clr_thr) w_alarm_hi_nxt = 1'b0;
        if (temp_in < r_lo_thr)          w_alarm_lo_nxt = 1'b1;
        else if (temp_in > w_lo_clr_thr) w_alarm_lo_nxt = 1'b0;
    end

    // Sample path: last temperature and live alarms, independent of the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_temp <= '0;
            r_alarm_hi  <= 1'b0;
            r_alarm_lo  <= 1'b0;
        end else if (temp_vld) begin
            r_last_temp <= temp_in;
            r_alarm_hi  <= w_alarm_hi_nxt;
            r_alarm_lo  <= w_alarm_lo_nxt;
        end
    end

    // Sticky alarm: a live alarm on a sample overrides a concurrent CLR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          r_sticky <= 1'b0;
        else if (temp_vld && (w_alarm_hi_nxt || w_alarm_lo_nxt)) r_sticky <= 1'b1;
        else if (w_exec && w_clr)                            r_sticky <= 1'b0;
    end

    assign ready        = w_ready;
    assign valid        = w_valid;
    assign status       = r_status;
    assign rdata        = r_rdata;
    assign alarm_hi     = r_alarm_hi;
    assign alarm_lo     = r_alarm_lo;
    assign alarm_sticky = r_sticky;

endmodule

// File: tb/tb_tmon_responder.sv
// Directed bench for tmon_responder with a response scoreboard.

module tb_tmon_responder;
    import tmon_pkg::*;

    typedef struct packed {
        tmon_status_t st;
        logic [7:0]   rd;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    tmon_op_t     op;
    logic [7:0]   opnd;
    tmon_status_t status;
    logic         valid;
    logic         ready;
    logic [7:0]   rdata;
    logic [7:0]   temp_in;
    logic         temp_vld;
    logic         alarm_hi;
    logic         alarm_lo;
    logic         alarm_sticky;

    resp_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_resp  = 0;
    int    n_push  = 0;
    logic  prev_valid = 1'b0;

    always #5 clk = ~clk;

    tmon_responder #(
        .DW(8),
        .HYST(2),
        .HI_RST(8'd200),
        .LO_RST(8'd10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op(op),
        .opnd(opnd),
        .status(status),
        .valid(valid),
        .ready(ready),
        .rdata(rdata),
        .temp_in(temp_in),
        .temp_vld(temp_vld),
        .alarm_hi(alarm_hi),
        .alarm_lo(alarm_lo),
        .alarm_sticky(alarm_sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every valid strobe
    always @(negedge clk) begin
        resp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (valid) begin
                n_resp++;
                check("valid_one_cycle", prev_valid, 0);
                check("resp_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("resp_status", status, e.st);
                    check("resp_rdata", rdata, e.rd);
                end
            end
            prev_valid = valid;
        end
    end

    task automatic push_exp(input tmon_status_t st, input logic [7:0] rd);
        sb_q.push_back(resp_t'{st, rd});
        n_push++;
    endtask

    task automatic send_cmd(input tmon_op_t o, input logic [7:0] d,
                            input tmon_status_t est, input logic [7:0] erd);
        int waited;
        waited = 0;
        while (ready !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_cmd", ready, 1);
        op   = o;
        opnd = d;
        push_exp(est, erd);
        @(posedge clk); #1;
        op = TMON_NOP;
        check("exec_valid_low", valid, 0);
        check("exec_ready_low", ready, 0);
        @(posedge clk); #1;
        check("resp_valid_high", valid, 1);
        @(posedge clk); #1;
        check("ready_after_resp", ready, 1);
    endtask

    task automatic sample(input logic [7:0] t);
        temp_in  = t;
        temp_vld = 1'b1;
        @(posedge clk); #1;
        temp_vld = 1'b0;
    endtask

    initial begin
        int nv;
        int nrl;
        rst_n    = 1'b0;
        op       = TMON_NOP;
        opnd     = '0;
        temp_in  = '0;
        temp_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_status", status, TMON_OK);
        check("rst_rdata", rdata, 0);
        check("rst_alarm_hi", alarm_hi, 0);
        check("rst_alarm_lo", alarm_lo, 0);
        check("rst_sticky", alarm_sticky, 0);

        // Reset thresholds
        send_cmd(TMON_RD_HI, 8'd0, TMON_OK, 8'd200);
        send_cmd(TMON_RD_LO, 8'd0, TMON_OK, 8'd10);

        // Threshold writes and legality checks
        send_cmd(TMON_SET_HI, 8'd150, TMON_OK, 8'd0);
        send_cmd(TMON_SET_LO, 8'd160, TMON_ERR, 8'd0);
        send_cmd(TMON_RD_LO, 8'd0, TMON_OK, 8'd10);
        send_cmd(TMON_RD_HI, 8'd0, TMON_OK, 8'd150);
        send_cmd(TMON_SET_HI, 8'd10, TMON_ERR, 8'd0);
        send_cmd(TMON_SET_LO, 8'd150, TMON_ERR, 8'd0);
        send_cmd(tmon_op_t'(3'd7), 8'd55, TMON_ERR, 8'd0);
        send_cmd(TMON_RD_HI, 8'd0, TMON_OK, 8'd150);

        // High alarm with hysteresis (clear below 148)
        sample(8'd151);
        check("hi_set", alarm_hi, 1);
        check("hi_sticky", alarm_sticky, 1);
        sample(8'd149);
        check("hi_hold_149", alarm_hi, 1);
        sample(8'd148);
        check("hi_hold_148", alarm_hi, 1);
        sample(8'd147);
        check("hi_clear_147", alarm_hi, 0);
        check("sticky_kept", alarm_sticky, 1);
        send_cmd(TMON_CLR, 8'd0, TMON_OK, 8'd0);
        check("sticky_cleared", alarm_sticky, 0);

        // Low alarm with hysteresis (clear above 12)
        sample(8'd9);
        check("lo_set", alarm_lo, 1);
        check("lo_sticky", alarm_sticky, 1);
        send_cmd(TMON_RD_TEMP, 8'd0, TMON_ALARM, 8'd9);
        sample(8'd12);
        check("lo_hold_12", alarm_lo, 1);
        sample(8'd13);
        check("lo_clear_13", alarm_lo, 0);

        // Op held continuously: one accept per three cycles
        push_exp(TMON_OK, 8'd13);
        push_exp(TMON_OK, 8'd13);
        push_exp(TMON_OK, 8'd13);
        nv  = 0;
        nrl = 0;
        op  = TMON_RD_TEMP;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) nv++;
            if (ready !== 1'b1) nrl++;
        end
        op = TMON_NOP;
        check("hold_valid_count", nv, 3);
        check("hold_ready_low", nrl, 6);
        @(posedge clk); #1;
        check("hold_sb_empty", sb_q.size(), 0);

        // Reset during EXEC of SET_HI 100
        op   = TMON_SET_HI;
        opnd = 8'd100;
        @(posedge clk); #1;
        op = TMON_NOP;
        check("mid_exec_ready", ready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_valid", valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_resp", n_resp, n_push);
        send_cmd(TMON_RD_HI, 8'd0, TMON_OK, 8'd200);

        // Saturated hysteresis at the bottom of the range
        send_cmd(TMON_SET_LO, 8'd0, TMON_OK, 8'd0);
        send_cmd(TMON_SET_HI, 8'd1, TMON_OK, 8'd0);
        sample(8'd5);
        check("sat_hi_set", alarm_hi, 1);
        sample(8'd0);
        check("sat_hi_no_wrap", alarm_hi, 1);
        check("sat_lo_zero", alarm_lo, 0);

        // Saturated hysteresis at the top of the range
        send_cmd(TMON_SET_HI, 8'd255, TMON_OK, 8'd0);
        sample(8'd100);
        check("sat_hi_clear", alarm_hi, 0);
        send_cmd(TMON_SET_LO, 8'd254, TMON_OK, 8'd0);
        sample(8'd253);
        check("sat_lo_set", alarm_lo, 1);
        check("sat_hi_hold", alarm_hi, 0);
        sample(8'd255);
        check("sat_lo_no_wrap", alarm_lo, 1);
        check("sat_hi_255", alarm_hi, 0);

        // Sample asserting an alarm during EXEC of CLR keeps sticky set
        op = TMON_CLR;
        push_exp(TMON_OK, 8'd0);
        @(posedge clk); #1;
        op       = TMON_NOP;
        temp_in  = 8'd253;
        temp_vld = 1'b1;
        @(posedge clk); #1;
        temp_vld = 1'b0;
        check("clr_set_wins", alarm_sticky, 1);
        @(posedge clk); #1;
        check("clr_ready_back", ready, 1);

        check("final_sb_empty", sb_q.size(), 0);
        check("final_resp_count", n_resp, n_push);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
